// File: rtl/stopwatch_timer.sv
// MIN:SEC stopwatch / countdown core, single clock domain.
// Counts up or down on incTick, supports field adjust, pause toggling
// and a terminal DONE state for countdown expiry.
//
// state  | meaning
// -------+-----------------------------------------------------------
// RUN    | counting on incTick (direction from mode)
// PAUSE  | value frozen; pause rising edge returns to RUN
// ADJUST | adjTick steps the field chosen by sel; blink toggles
// DONE   | countdown reached 00:00; value held until adj is raised
module stopwatch_timer #(
    parameter int MIN_W   = 6,
    parameter int SEC_W   = 6,
    parameter int MIN_MAX = 59,
    parameter int SEC_MAX = 59
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             incTick,
    input  logic             adjTick,
    input  logic             blinkTick,
    input  logic             adj,
    input  logic             sel,
    input  logic             pause,
    input  logic             mode,
    output logic [MIN_W-1:0] minutes,
    output logic [SEC_W-1:0] seconds,
    output logic             paused,
    output logic             expired,
    output logic             wrapped,
    output logic             blink
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_PAUSE  = 2'd1;
    localparam logic [1:0] ST_ADJUST = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [MIN_W-1:0] MIN_TOP = MIN_W'(MIN_MAX);
    localparam logic [SEC_W-1:0] SEC_TOP = SEC_W'(SEC_MAX);
    localparam logic [SEC_W-1:0] SEC_ONE = SEC_W'(1);

    logic [1:0]       state;
    logic [1:0]       ret_state;
    logic [1:0]       nxt_state;
    logic [1:0]       nxt_ret;
    logic             pause_q;
    logic             pause_rise;
    logic [MIN_W-1:0] nxt_min;
    logic [SEC_W-1:0] nxt_sec;
    logic             nxt_wrapped;
    logic             nxt_blink;

    assign pause_rise = pause & ~pause_q;

    // Next-state, next-value and pulse computation; adj outranks everything but rst.
    always_comb begin
        nxt_state   = state;
        nxt_ret     = ret_state;
        nxt_min     = minutes;
        nxt_sec     = seconds;
        nxt_wrapped = 1'b0;
        nxt_blink   = 1'b0;
        case (state)
            ST_RUN: begin
                if (adj) begin
                    nxt_state = ST_ADJUST;
                    nxt_ret   = ST_RUN;
                end else if (pause_rise) begin
                    nxt_state = ST_PAUSE;
                end else if (incTick) begin
                    if (!mode) begin
                        if (seconds < SEC_TOP) begin
                            nxt_sec = seconds + 1'b1;
                        end else begin
                            nxt_sec = '0;
                            if (minutes < MIN_TOP) begin
                                nxt_min = minutes + 1'b1;
                            end else begin
                                nxt_min     = '0;
                                nxt_wrapped = 1'b1;
                            end
                        end
                    end else begin
                        if (seconds != '0) begin
                            nxt_sec = seconds - 1'b1;
                        end else if (minutes != '0) begin
                            nxt_sec = SEC_TOP;
                            nxt_min = minutes - 1'b1;
                        end
                        // Result is 00:00 only from 00:01 or an already-zero value.
                        if (minutes == '0 && seconds <= SEC_ONE) begin
                            nxt_state = ST_DONE;
                        end
                    end
                end
            end
            ST_PAUSE: begin
                if (adj) begin
                    nxt_state = ST_ADJUST;
                    nxt_ret   = ST_PAUSE;
                end else if (pause_rise) begin
                    nxt_state = ST_RUN;
                end
            end
            ST_ADJUST: begin
                if (!adj) begin
                    nxt_state = ret_state;
                end else begin
                    nxt_blink = blinkTick ? ~blink : blink;
                    if (adjTick) begin
                        if (!sel) begin
                            nxt_min = (minutes >= MIN_TOP) ? '0 : minutes + 1'b1;
                        end else begin
                            nxt_sec = (seconds >= SEC_TOP) ? '0 : seconds + 1'b1;
                        end
                    end
                end
            end
            ST_DONE: begin
                // Leaving an expired countdown parks in PAUSE so it does not restart on its own.
                if (adj) begin
                    nxt_state = ST_ADJUST;
                    nxt_ret   = ST_PAUSE;
                end
            end
            default: begin
                nxt_state = ST_RUN;
            end
        endcase
    end

    // State and output registers; status flags decoded from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            ret_state <= ST_RUN;
            pause_q   <= 1'b0;
            minutes   <= '0;
            seconds   <= '0;
            paused    <= 1'b0;
            expired   <= 1'b0;
            wrapped   <= 1'b0;
            blink     <= 1'b0;
        end else begin
            state     <= nxt_state;
            ret_state <= nxt_ret;
            pause_q   <= pause;
            minutes   <= nxt_min;
            seconds   <= nxt_sec;
            paused    <= (nxt_state == ST_PAUSE);
            expired   <= (nxt_state == ST_DONE);
            wrapped   <= nxt_wrapped;
            blink     <= nxt_blink;
        end
    end

endmodule

// File: tb/tb_stopwatch_timer.sv
// Bench for stopwatch_timer: expected outputs are queued as stimulus is
// driven and popped for comparison one clock later.
module tb_stopwatch_timer;

    logic       clk = 1'b0;
    logic       rst, incTick, adjTick, blinkTick, adj, sel, pause, mode;
    logic [5:0] minutes, seconds;
    logic       paused, expired, wrapped, blink;

    typedef struct packed {
        logic [5:0] m;
        logic [5:0] s;
        logic       p;
        logic       e;
        logic       w;
        logic       b;
    } obs_t;

    obs_t sb[$];
    obs_t exp_v, got_v;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    stopwatch_timer #(.MIN_W(6), .SEC_W(6), .MIN_MAX(59), .SEC_MAX(59)) dut (
        .clk(clk), .rst(rst), .incTick(incTick), .adjTick(adjTick),
        .blinkTick(blinkTick), .adj(adj), .sel(sel), .pause(pause), .mode(mode),
        .minutes(minutes), .seconds(seconds), .paused(paused), .expired(expired),
        .wrapped(wrapped), .blink(blink)
    );

    function automatic obs_t mk(input int m, input int s, input logic p,
                                input logic e, input logic w, input logic b);
        obs_t o;
        o.m = 6'(m); o.s = 6'(s); o.p = p; o.e = e; o.w = w; o.b = b;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.m = minutes; o.s = seconds; o.p = paused; o.e = expired; o.w = wrapped; o.b = blink;
        return o;
    endfunction

    // One clock with the given tick pulses; returns 1 ns after the edge.
    task automatic step(input logic i, input logic a, input logic bk);
        incTick = i; adjTick = a; blinkTick = bk;
        @(posedge clk);
        #1;
        incTick = 1'b0; adjTick = 1'b0; blinkTick = 1'b0;
    endtask

    // Reset, then load m:s through adjust mode and return to RUN.
    task automatic goto(input int m, input int s);
        rst = 1'b1; step(0, 0, 0);
        rst = 1'b0; adj = 1'b1; step(0, 0, 0);
        sel = 1'b0; repeat (m) step(0, 1, 0);
        sel = 1'b1; repeat (s) step(0, 1, 0);
        adj = 1'b0; step(0, 0, 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sb.push_back(mk(0, 0, 0, 0, 0, 0));
        step(1, 1, 1);
        exp_v = sb.pop_front(); got_v = sample(); vectors++;
        if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL reset got %h expected %h", got_v, exp_v);
        end
        rst = 1'b0;
    endtask

    task automatic test_up_count();
        goto(0, 0);
        mode = 1'b0;
        for (int i = 0; i < 60; i++) begin
            sb.push_back(mk((i + 1) / 60, (i + 1) % 60, 0, 0, 0, 0));
            step(1, 0, 0);
            exp_v = sb.pop_front(); got_v = sample(); vectors++;
            if (got_v !== exp_v) begin
                miscompares++;
                $display("FAIL up_count tick %0d got %h expected %h", i, got_v, exp_v);
            end
        end
        goto(59, 59);
        sb.push_back(mk(0, 0, 0, 0, 1, 0));
        sb.push_back(mk(0, 0, 0, 0, 0, 0));
        sb.push_back(mk(0, 1, 0, 0, 0, 0));
        step(1, 0, 0);
        exp_v = sb.pop_front(); got_v = sample(); vectors++;
        if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL wrap got %h expected %h", got_v, exp_v);
        end
        step(0, 0, 0);
        exp_v = sb.pop_front(); got_v = sample(); vectors++;
        if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL wrap_pulse_end got %h expected %h", got_v, exp_v);
        end
        step(1, 0, 0);
        exp_v = sb.pop_front(); got_v = sample(); vectors++;
        if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL after_wrap got %h expected %h", got_v, exp_v);
        end
    endtask

    task automatic test_adjust();
        int exp_s[3] = '{59, 0, 1};
        goto(0, 58);
        adj = 1'b1; sel = 1'b1;
        step(0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            sb.push_back(mk(0, exp_s[i], 0, 0, 0, 0));
            step(1, 1, 0);
            exp_v = sb.pop_front(); got_v = sample(); vectors++;
            if (got_v !== exp_v) begin
                miscompares++;
                $display("FAIL adjust_sec step %0d got %h expected %h", i, got_v, exp_v);
            end
        end
        for (int i = 0; i < 3; i++) begin
            sb.push_back(mk(0, 1, 0, 0, 0, (i % 2 == 0) ? 1'b1 : 1'b0));
            step(0, 0, 1);
            exp_v = sb.pop_front(); got_v = sample(); vectors++;
            if (got_v !== exp_v) begin
                miscompares++;
                $display("FAIL blink %0d got %h expected %h", i, got_v, exp_v);
            end
        end
        adj = 1'b0;
        sb.push_back(mk(0, 1, 0, 0, 0, 0));
        sb.push_back(mk(0, 2, 0, 0, 0, 0));
        step(0, 0, 0);
        exp_v = sb.pop_front(); got_v = sample(); vectors++;
        if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL adjust_exit got %h expected %h", got_v, exp_v);
        end
        step(1, 0, 0);
        exp_v = sb.pop_front(); got_v = sample(); vectors++;
        if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL adjust_resume got %h expected %h", got_v, exp_v);
        end
    endtask

    task automatic test_countdown();
        goto(0, 2);
        mode = 1'b1;
        sb.push_back(mk(0, 1, 0, 0, 0, 0));
        sb.push_back(mk(0, 0, 0, 1, 0, 0));
        for (int i = 0; i < 3; i++) sb.push_back(mk(0, 0, 0, 1, 0, 0));
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0);
            exp_v = sb.pop_front(); got_v = sample(); vectors++;
            if (got_v !== exp_v) begin
                miscompares++;
                $display("FAIL countdown tick %0d got %h expected %h", i, got_v, exp_v);
            end
        end
        pause = 1'b1;
        sb.push_back(mk(0, 0, 0, 1, 0, 0));
        step(1, 0, 0);
        exp_v = sb.pop_front(); got_v = sample(); vectors++;
        if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL done_ignores_pause got %h expected %h", got_v, exp_v);
        end
        pause = 1'b0;
        goto(1, 0);
        sb.push_back(mk(0, 59, 0, 0, 0, 0));
        step(1, 0, 0);
        exp_v = sb.pop_front(); got_v = sample(); vectors++;
        if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL down_borrow got %h expected %h", got_v, exp_v);
        end
        mode = 1'b0;
    endtask

    task automatic test_pause();
        goto(5, 10);
        mode = 1'b0;
        pause = 1'b1;
        sb.push_back(mk(5, 10, 1, 0, 0, 0));
        step(1, 0, 0);
        exp_v = sb.pop_front(); got_v = sample(); vectors++;
        if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL pause_enter got %h expected %h", got_v, exp_v);
        end
        for (int i = 0; i < 5; i++) begin
            sb.push_back(mk(5, 10, 1, 0, 0, 0));
            step(1, 0, 0);
            exp_v = sb.pop_front(); got_v = sample(); vectors++;
            if (got_v !== exp_v) begin
                miscompares++;
                $display("FAIL pause_hold %0d got %h expected %h", i, got_v, exp_v);
            end
        end
        pause = 1'b0; step(0, 0, 0);
        pause = 1'b1;
        sb.push_back(mk(5, 10, 0, 0, 0, 0));
        sb.push_back(mk(5, 11, 0, 0, 0, 0));
        step(0, 0, 0);
        exp_v = sb.pop_front(); got_v = sample(); vectors++;
        if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL pause_exit got %h expected %h", got_v, exp_v);
        end
        step(1, 0, 0);
        exp_v = sb.pop_front(); got_v = sample(); vectors++;
        if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL pause_resume got %h expected %h", got_v, exp_v);
        end
        pause = 1'b0;
        step(0, 0, 0);
    endtask

    task automatic test_adj_return();
        goto(3, 4);
        pause = 1'b1; step(0, 0, 0);
        pause = 1'b0; adj = 1'b1;
        sb.push_back(mk(3, 4, 0, 0, 0, 0));
        step(0, 0, 0);
        adj = 1'b0;
        sb.push_back(mk(3, 4, 1, 0, 0, 0));
        step(0, 0, 0);
        sb.push_back(mk(3, 4, 1, 0, 0, 0));
        step(1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            exp_v = sb.pop_front(); got_v = sample();
            if (i == 2) begin
                vectors++;
                if (got_v !== exp_v) begin
                    miscompares++;
                    $display("FAIL pause_adj_return got %h expected %h", got_v, exp_v);
                end
            end
        end
        goto(0, 1);
        mode = 1'b1;
        step(1, 0, 0);
        adj = 1'b1;
        sb.push_back(mk(0, 0, 0, 0, 0, 0));
        step(0, 0, 0);
        exp_v = sb.pop_front(); got_v = sample(); vectors++;
        if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL done_adj got %h expected %h", got_v, exp_v);
        end
        adj = 1'b0;
        sb.push_back(mk(0, 0, 1, 0, 0, 0));
        step(1, 0, 0);
        exp_v = sb.pop_front(); got_v = sample(); vectors++;
        if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL done_exit_pause got %h expected %h", got_v, exp_v);
        end
        mode = 1'b0;
        goto(2, 2);
        adj = 1'b1; pause = 1'b1;
        step(0, 0, 0);
        adj = 1'b0;
        step(0, 0, 0);
        sb.push_back(mk(2, 3, 0, 0, 0, 0));
        step(1, 0, 0);
        exp_v = sb.pop_front(); got_v = sample(); vectors++;
        if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL adj_beats_pause got %h expected %h", got_v, exp_v);
        end
        pause = 1'b0;
        step(0, 0, 0);
    endtask

    task automatic test_rst_in_adjust();
        goto(4, 4);
        adj = 1'b1; step(0, 0, 0);
        sb.push_back(mk(4, 4, 0, 0, 0, 1));
        step(0, 0, 1);
        exp_v = sb.pop_front(); got_v = sample(); vectors++;
        if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL blink_before_rst got %h expected %h", got_v, exp_v);
        end
        rst = 1'b1;
        sb.push_back(mk(0, 0, 0, 0, 0, 0));
        step(0, 1, 1);
        exp_v = sb.pop_front(); got_v = sample(); vectors++;
        if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL rst_adjust got %h expected %h", got_v, exp_v);
        end
        rst = 1'b0; adj = 1'b0;
        sb.push_back(mk(0, 1, 0, 0, 0, 0));
        step(1, 0, 0);
        exp_v = sb.pop_front(); got_v = sample(); vectors++;
        if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL rst_then_run got %h expected %h", got_v, exp_v);
        end
    endtask

    initial begin
        rst = 1'b1; incTick = 1'b0; adjTick = 1'b0; blinkTick = 1'b0;
        adj = 1'b0; sel = 1'b0; pause = 1'b0; mode = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_up_count();
        test_adjust();
        test_countdown();
        test_pause();
        test_adj_return();
        test_rst_in_adjust();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
